// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Index width with a floor of one bit so single-entry ranges stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_rr_pick.sv
// rtl/fifo_wr_rr_pick.sv - rotate-priority picker: first set request at or above ptr, with wrap
module fifo_wr_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] j;

  // Scan from the far end down so the nearest candidate to ptr is written last and wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one async-FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA  = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wreset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     write,
  output logic [DATA-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(BURST + 1);

  arb_state_t      state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [CW-1:0]   beat_cnt, beat_cnt_n;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [DATA-1:0] lane [NREQ];
  logic            own_valid;
  logic            beat;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DATA +: DATA];
  end

  fifo_wr_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign own_valid = req_valid[owner];
  assign beat      = (state == GRANT) && own_valid && !wfull;

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // A dropped valid releases even under wfull; wfull alone only stalls the grant.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_n    = pick_idx;
          beat_cnt_n = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (!own_valid || (beat && beat_cnt == CW'(BURST - 1))) begin
          state_n  = IDLE;
          rr_ptr_n = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end else if (beat) begin
          beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == GRANT && !wfull) req_ready = NREQ'(1) << owner;
  end

  assign write  = beat;
  assign wdata  = beat ? lane[owner] : '0;
  assign gnt_id = owner;
  assign busy   = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic         wclk = 1'b0;
  logic         wreset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wfull;
  logic         write;
  logic [31:0]  wdata;
  logic [1:0]   gnt_id;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] srcq [4][$];

  logic        s_write;
  logic [31:0] s_wdata;
  logic [1:0]  s_gnt;
  logic [3:0]  s_ready;
  logic        s_busy;

  fifo_wr_arbiter #(.DATA(32), .NREQ(4), .BURST(4)) dut (
    .wclk      (wclk),
    .wreset    (wreset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .write     (write),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[i*32 +: 32] = srcq[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*32 +: 32] = '0;
      end
    end
  endtask

  // Sample at negedge (the beat the next posedge commits), retire handshaken beats, then advance.
  task automatic cycle();
    @(negedge wclk);
    s_write = write;
    s_wdata = wdata;
    s_gnt   = gnt_id;
    s_ready = req_ready;
    s_busy  = busy;
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
    @(posedge wclk);
    #1;
    drive_inputs();
  endtask

  task automatic do_reset();
    wreset = 1'b1;
    wfull  = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    drive_inputs();
    @(posedge wclk);
    #1;
    wreset = 1'b0;
  endtask

  task automatic test_reset();
    wreset = 1'b1;
    wfull  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      srcq[i].delete();
      srcq[i].push_back(32'h100 + i);
    end
    drive_inputs();
    @(posedge wclk);
    #2;
    checks++; if (write !== 1'b0)     begin errors++; $display("FAIL reset_write: got %b expected 0", write); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", req_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (gnt_id !== 2'd0)    begin errors++; $display("FAIL reset_gnt: got %0d expected 0", gnt_id); end
    checks++; if (wdata !== 32'h0)    begin errors++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    @(posedge wclk);
    #1;
    wreset = 1'b0;
    cycle();
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 0", s_write); end
    cycle();
    checks++; if (s_write !== 1'b1 || s_wdata !== 32'h100)
      begin errors++; $display("FAIL midrst_beat: got %b/%h expected 1/00000100", s_write, s_wdata); end
    wreset = 1'b1;
    #1;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL midrst_write: got %b expected 0", write); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    do_reset();
  endtask

  task automatic test_single_stream();
    logic        exp_w [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    logic        exp_b [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [31:0] exp_d [10] = '{0, 32'h20, 32'h21, 32'h22, 32'h23, 0, 32'h24, 32'h25, 0, 0};
    do_reset();
    for (int n = 0; n < 6; n++) srcq[2].push_back(32'h20 + n);
    drive_inputs();
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (s_write !== exp_w[k] || s_wdata !== exp_d[k] || s_busy !== exp_b[k])
        begin errors++; $display("FAIL single_c%0d: got w=%b d=%h b=%b expected w=%b d=%h b=%b",
                                 k, s_write, s_wdata, s_busy, exp_w[k], exp_d[k], exp_b[k]); end
      if (exp_w[k]) begin
        checks++;
        if (s_gnt !== 2'd2) begin errors++; $display("FAIL single_gnt_c%0d: got %0d expected 2", k, s_gnt); end
      end
    end
  endtask

  task automatic test_contention();
    int g, pos;
    logic        ew;
    logic [1:0]  eg;
    logic [31:0] ed;
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 40; n++) srcq[i].push_back((i << 8) | n);
    drive_inputs();
    for (int k = 0; k < 40; k++) begin
      cycle();
      ew = 1'b0; eg = 2'd0; ed = 32'h0;
      if (k > 0) begin
        g   = (k - 1) / 5;
        pos = (k - 1) % 5;
        if (pos < 4) begin
          ew = 1'b1;
          eg = 2'(g % 4);
          ed = ((g % 4) << 8) | ((g / 4) * 4 + pos);
        end
      end
      checks++;
      if (s_write !== ew || s_wdata !== ed || (ew && s_gnt !== eg))
        begin errors++; $display("FAIL contend_c%0d: got w=%b g=%0d d=%h expected w=%b g=%0d d=%h",
                                 k, s_write, s_gnt, s_wdata, ew, eg, ed); end
    end
  endtask

  task automatic test_backpressure();
    logic        exp_w [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    logic        exp_b [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] exp_d [9] = '{0, 32'h10, 32'h11, 0, 0, 0, 32'h12, 32'h13, 0};
    do_reset();
    for (int n = 0; n < 4; n++) srcq[1].push_back(32'h10 + n);
    srcq[1].push_back(32'h14);
    drive_inputs();
    for (int k = 0; k < 9; k++) begin
      wfull = (k >= 3 && k <= 5);
      cycle();
      checks++;
      if (s_write !== exp_w[k] || s_wdata !== exp_d[k] || s_busy !== exp_b[k])
        begin errors++; $display("FAIL bp_c%0d: got w=%b d=%h b=%b expected w=%b d=%h b=%b",
                                 k, s_write, s_wdata, s_busy, exp_w[k], exp_d[k], exp_b[k]); end
      if (k >= 3 && k <= 5) begin
        checks++;
        if (s_ready !== 4'h0 || s_gnt !== 2'd1)
          begin errors++; $display("FAIL bp_hold_c%0d: got ready=%h gnt=%0d expected 0/1", k, s_ready, s_gnt); end
      end
    end
    wfull = 1'b0;
  endtask

  task automatic test_early_release();
    logic        exp_w [9] = '{0, 1, 0, 0, 1, 1, 0, 0, 1};
    logic        exp_b [9] = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
    logic [1:0]  exp_g [9] = '{0, 0, 0, 0, 3, 3, 3, 3, 0};
    logic [31:0] exp_d [9] = '{0, 32'hA0, 0, 0, 32'hD0, 32'hD1, 0, 0, 32'hA1};
    do_reset();
    srcq[0].push_back(32'hA0);
    srcq[3].push_back(32'hD0);
    srcq[3].push_back(32'hD1);
    drive_inputs();
    for (int k = 0; k < 9; k++) begin
      cycle();
      if (k == 2) begin
        srcq[0].push_back(32'hA1);
        drive_inputs();
      end
      checks++;
      if (s_write !== exp_w[k] || s_wdata !== exp_d[k] || s_busy !== exp_b[k] || (exp_b[k] && s_gnt !== exp_g[k]))
        begin errors++; $display("FAIL early_c%0d: got w=%b d=%h b=%b g=%0d expected w=%b d=%h b=%b g=%0d",
                                 k, s_write, s_wdata, s_busy, s_gnt, exp_w[k], exp_d[k], exp_b[k], exp_g[k]); end
    end
  endtask

  task automatic test_reset_recovery();
    do_reset();
    for (int n = 0; n < 4; n++) srcq[3].push_back(32'h30 + n);
    drive_inputs();
    cycle();
    cycle();
    checks++;
    if (s_write !== 1'b1 || s_gnt !== 2'd3)
      begin errors++; $display("FAIL recov_pre: got w=%b g=%0d expected 1/3", s_write, s_gnt); end
    wreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      srcq[i].delete();
      srcq[i].push_back(32'h50 + i);
    end
    drive_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL recov_busy: got %b expected 0", busy); end
    @(posedge wclk);
    #1;
    wreset = 1'b0;
    cycle();
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL recov_idle: got %b expected 0", s_write); end
    cycle();
    checks++;
    if (s_write !== 1'b1 || s_gnt !== 2'd0 || s_wdata !== 32'h50)
      begin errors++; $display("FAIL recov_first: got w=%b g=%0d d=%h expected 1/0/00000050", s_write, s_gnt, s_wdata); end
  endtask

  initial begin
    wreset    = 1'b1;
    wfull     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    #1;
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_recovery();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
